// File: rtl/cpu_pkg.sv
// Shared types for the execute stage: ALU opcode encoding, MDU FSM states and M-register bubble values.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int MDU_ITERS = XLEN;

  localparam logic [31:0] DBG_PC_BUBBLE = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_MUL  = 4'd12,
    ALU_MULH = 4'd13,
    ALU_DIV  = 4'd14,
    ALU_REM  = 4'd15
  } aluc_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_mdu(input aluc_t op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 signed multiply/divide on magnitudes with a shared 2*XLEN accumulator.
// ITERS cycles in BUSY, result held in DONE until hold_i drops; kill_i aborts to IDLE.
module mdu_iter
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  aluc_t           op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            hold_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(ITERS);

  mdu_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  aluc_t             op_q, op_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d, bzero_q, bzero_d;

  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     add_sum, sub_diff;
  logic [2*XLEN-1:0] shl, prod;
  logic [XLEN-1:0]   quo, rem;
  logic              is_mul;

  assign mag_a    = a_i[XLEN-1] ? -a_i : a_i;
  assign mag_b    = b_i[XLEN-1] ? -b_i : b_i;
  assign is_mul   = (op_q == ALU_MUL) || (op_q == ALU_MULH);
  assign add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign shl      = {acc_q[2*XLEN-2:0], 1'b0};
  assign sub_diff = {1'b0, shl[2*XLEN-1:XLEN]} - {1'b0, opnd_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    bzero_d = bzero_q;
    case (state_q)
      MDU_IDLE: begin
        if (start_i && !kill_i) begin
          state_d = MDU_BUSY;
          cnt_d   = CW'(ITERS - 1);
          op_d    = op_i;
          neg_a_d = a_i[XLEN-1];
          neg_b_d = b_i[XLEN-1];
          bzero_d = (b_i == '0);
          // Multiply: multiplier in the low half, multiplicand added to the high half.
          // Divide: dividend in the low half, divisor subtracted from the shifted high half.
          if ((op_i == ALU_MUL) || (op_i == ALU_MULH)) begin
            acc_d  = {{XLEN{1'b0}}, mag_b};
            opnd_d = mag_a;
          end else begin
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
          end
        end
      end
      MDU_BUSY: begin
        if (kill_i) begin
          state_d = MDU_IDLE;
        end else begin
          if (is_mul) begin
            acc_d = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
          end else begin
            acc_d = sub_diff[XLEN] ? shl : {sub_diff[XLEN-1:0], shl[XLEN-1:1], 1'b1};
          end
          if (cnt_q == '0) begin
            state_d = MDU_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      MDU_DONE: begin
        if (kill_i || !hold_i) begin
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= ALU_ADD;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      bzero_q <= bzero_d;
    end
  end

  // Remainder follows the dividend's sign, which also yields rem == dividend on divide-by-zero.
  assign prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo  = bzero_q ? '1 :
                ((neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
  assign rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    case (op_q)
      ALU_MUL:  result_o = prod[XLEN-1:0];
      ALU_MULH: result_o = prod[2*XLEN-1:XLEN];
      ALU_DIV:  result_o = quo;
      default:  result_o = rem;
    endcase
  end

  assign busy_o = (state_q == MDU_BUSY);
  assign done_o = (state_q == MDU_DONE);

endmodule

// File: rtl/pipeline_reg.sv
// Generic stage register: reset > stall (hold) > bubble (load RST_VAL) > capture.
// One-cycle latency; stall_i freezes contents.
module pipeline_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         stall_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = d_i;
    if (stall_i) begin
      q_d = q_q;
    end else if (bubble_i) begin
      q_d = RST_VAL;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU, iterative MDU and the E->M pipeline register.
// ALU ops land in M one edge later; MDU ops hold E via e_stall_req for MDU_ITERS+1 cycles.
module exec_stage
  import cpu_pkg::*;
#(
  parameter int XLEN      = cpu_pkg::XLEN,
  parameter int MDU_ITERS = XLEN
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            e_wreg,
  input  logic            e_m2reg,
  input  logic            e_wmem,
  input  logic            e_setcond,
  input  logic            e_do_jmp_in_m,
  input  logic            e_mode,
  input  logic [3:0]      e_aluc,
  input  logic [XLEN-1:0] e_alua,
  input  logic [XLEN-1:0] e_alub,
  input  logic [XLEN-1:0] e_data,
  input  logic [4:0]      e_rn,
  input  logic [31:0]     dbg_e_pc,
  input  logic [47:0]     dbg_e_inst,
  input  logic            e_kill,
  input  logic            m_stall,
  input  logic            m_bubble,
  output logic            e_stall_req,
  output logic            m_wreg,
  output logic            m_m2reg,
  output logic            m_wmem,
  output logic            m_setcond,
  output logic            m_do_jmp_in_m,
  output logic            m_mode,
  output logic [XLEN-1:0] m_alu,
  output logic [XLEN-1:0] m_data,
  output logic [4:0]      m_rn,
  output logic [31:0]     dbg_m_pc,
  output logic [47:0]     dbg_m_inst
);

  localparam int MW = 6 + 2 * XLEN + 5;

  aluc_t           op;
  logic            mdu_op, mdu_busy, mdu_done;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res, mdu_res, res;
  logic [MW-1:0]   m_d, m_q;
  logic [79:0]     dbg_q;

  assign op     = aluc_t'(e_aluc);
  assign mdu_op = is_mdu(op);
  assign shamt  = e_alub[4:0];

  always_comb begin
    case (op)
      ALU_ADD:  alu_res = e_alua + e_alub;
      ALU_SUB:  alu_res = e_alua - e_alub;
      ALU_AND:  alu_res = e_alua & e_alub;
      ALU_OR:   alu_res = e_alua | e_alub;
      ALU_XOR:  alu_res = e_alua ^ e_alub;
      ALU_NOR:  alu_res = ~(e_alua | e_alub);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(e_alua) < $signed(e_alub))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (e_alua < e_alub)};
      ALU_SLL:  alu_res = e_alua << shamt;
      ALU_SRL:  alu_res = e_alua >> shamt;
      ALU_SRA:  alu_res = $signed(e_alua) >>> shamt;
      ALU_LUI:  alu_res = e_alub << 16;
      default:  alu_res = '0;
    endcase
  end

  mdu_iter #(.XLEN(XLEN), .ITERS(MDU_ITERS)) u_mdu (
    .clk_i    (clk),
    .rst_i    (resetn),
    .start_i  (mdu_op),
    .kill_i   (e_kill),
    .op_i     (op),
    .a_i      (e_alua),
    .b_i      (e_alub),
    .hold_i   (m_stall),
    .busy_o   (mdu_busy),
    .done_o   (mdu_done),
    .result_o (mdu_res)
  );

  assign e_stall_req = (!mdu_busy && !mdu_done && mdu_op && !e_kill)
                     | mdu_busy
                     | (mdu_done && m_stall);

  assign res = mdu_op ? mdu_res : alu_res;
  assign m_d = {e_wreg, e_m2reg, e_wmem, e_setcond, e_do_jmp_in_m, e_mode, res, e_data, e_rn};

  pipeline_reg #(.W(MW), .RST_VAL('0)) u_m_reg (
    .clk_i    (clk),
    .rst_i    (resetn),
    .stall_i  (m_stall),
    .bubble_i (m_bubble | e_kill | e_stall_req),
    .d_i      (m_d),
    .q_o      (m_q)
  );

  pipeline_reg #(.W(80), .RST_VAL({DBG_PC_BUBBLE, 48'h0})) u_m_dbg (
    .clk_i    (clk),
    .rst_i    (resetn),
    .stall_i  (m_stall),
    .bubble_i (m_bubble | e_kill | e_stall_req),
    .d_i      ({dbg_e_pc, dbg_e_inst}),
    .q_o      (dbg_q)
  );

  assign {m_wreg, m_m2reg, m_wmem, m_setcond, m_do_jmp_in_m, m_mode, m_alu, m_data, m_rn} = m_q;
  assign {dbg_m_pc, dbg_m_inst} = dbg_q;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: stimulus pushes expected M contents, a negedge monitor pops on each new M capture.
module tb_exec_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        e_wreg, e_m2reg, e_wmem, e_setcond, e_do_jmp_in_m, e_mode;
  logic [3:0]  e_aluc;
  logic [31:0] e_alua, e_alub, e_data;
  logic [4:0]  e_rn;
  logic [31:0] dbg_e_pc;
  logic [47:0] dbg_e_inst;
  logic        e_kill, m_stall, m_bubble;
  logic        e_stall_req;
  logic        m_wreg, m_m2reg, m_wmem, m_setcond, m_do_jmp_in_m, m_mode;
  logic [31:0] m_alu, m_data;
  logic [4:0]  m_rn;
  logic [31:0] dbg_m_pc;
  logic [47:0] dbg_m_inst;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk(clk), .resetn(resetn),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_setcond(e_setcond),
    .e_do_jmp_in_m(e_do_jmp_in_m), .e_mode(e_mode),
    .e_aluc(e_aluc), .e_alua(e_alua), .e_alub(e_alub), .e_data(e_data), .e_rn(e_rn),
    .dbg_e_pc(dbg_e_pc), .dbg_e_inst(dbg_e_inst),
    .e_kill(e_kill), .m_stall(m_stall), .m_bubble(m_bubble),
    .e_stall_req(e_stall_req),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_wmem(m_wmem), .m_setcond(m_setcond),
    .m_do_jmp_in_m(m_do_jmp_in_m), .m_mode(m_mode),
    .m_alu(m_alu), .m_data(m_data), .m_rn(m_rn),
    .dbg_m_pc(dbg_m_pc), .dbg_m_inst(dbg_m_inst)
  );

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rn;
    logic [31:0] pc;
    logic [47:0] inst;
  } mexp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [5:0]  stall;
  } vec_t;

  localparam mexp_t M_RESET = '{ctrl: 6'h0, alu: 32'h0, data: 32'h0, rn: 5'h0,
                                pc: 32'hFFFF_FFFF, inst: 48'h0};

  vec_t vecs [20] = '{
    '{ALU_ADD,  32'd5,         32'd7,         32'd12,        6'd0},
    '{ALU_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF, 6'd0},
    '{ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         6'd0},
    '{ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         6'd0},
    '{ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 6'd0},
    '{ALU_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 6'd0},
    '{ALU_SLL,  32'd3,         32'd33,        32'd6,         6'd0},
    '{ALU_LUI,  32'hDEAD_BEEF, 32'h0000_1234, 32'h1234_0000, 6'd0},
    '{ALU_NOR,  32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F, 6'd0},
    '{ALU_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 6'd0},
    '{ALU_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 6'd0},
    '{ALU_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 6'd0},
    '{ALU_MUL,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 6'd33},
    '{ALU_MULH, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 6'd33},
    '{ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 6'd33},
    '{ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 6'd33},
    '{ALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 6'd33},
    '{ALU_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 6'd33},
    '{ALU_DIV,  32'd1234,      32'd0,         32'hFFFF_FFFF, 6'd33},
    '{ALU_REM,  32'd1234,      32'd0,         32'd1234,      6'd33}
  };

  mexp_t       sbq [$];
  int          n_checks   = 0;
  int          n_pass     = 0;
  int          n_pushed   = 0;
  int          n_captures = 0;
  logic [31:0] prev_pc    = 32'hFFFF_FFFF;
  logic [31:0] pc_next    = 32'h0000_0100;

  function automatic mexp_t m_now();
    mexp_t r;
    r.ctrl = {m_wreg, m_m2reg, m_wmem, m_setcond, m_do_jmp_in_m, m_mode};
    r.alu  = m_alu;
    r.data = m_data;
    r.rn   = m_rn;
    r.pc   = dbg_m_pc;
    r.inst = dbg_m_inst;
    return r;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic checkm(input string name, input mexp_t act, input mexp_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive_e(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] ctrl, input logic [31:0] pc);
    {e_wreg, e_m2reg, e_wmem, e_setcond, e_do_jmp_in_m, e_mode} = ctrl;
    e_aluc     = op;
    e_alua     = a;
    e_alub     = b;
    e_data     = ~pc;
    e_rn       = pc[6:2];
    dbg_e_pc   = pc;
    dbg_e_inst = {16'hC0DE, pc};
  endtask

  task automatic drive_idle();
    drive_e(4'd0, 32'h0, 32'h0, 6'h0, 32'hFFFF_FFFF);
    e_rn       = 5'h0;
    e_data     = 32'h0;
    dbg_e_inst = 48'h0;
  endtask

  task automatic push_exp(input logic [5:0] ctrl, input logic [31:0] alu, input logic [31:0] pc);
    mexp_t e;
    e.ctrl = ctrl;
    e.alu  = alu;
    e.data = ~pc;
    e.rn   = pc[6:2];
    e.pc   = pc;
    e.inst = {16'hC0DE, pc};
    sbq.push_back(e);
    n_pushed++;
  endtask

  // Entered and left at posedge+1; counts cycles with e_stall_req high before E may advance.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] ctrl,
                        input logic [31:0] exp_alu, input int exp_stall);
    logic [31:0] pc;
    int          cyc;
    bit          fin;
    pc = pc_next;
    pc_next = pc_next + 32'd4;
    drive_e(op, a, b, ctrl, pc);
    push_exp(ctrl, exp_alu, pc);
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 100) begin
      @(negedge clk);
      if (e_stall_req) cyc++;
      else fin = 1'b1;
      @(posedge clk);
      #1;
    end
    check32({name, " stall cycles"}, cyc, exp_stall);
    drive_idle();
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      prev_pc = 32'hFFFF_FFFF;
    end else begin
      if (dbg_m_pc != 32'hFFFF_FFFF && dbg_m_pc != prev_pc) begin
        n_captures++;
        if (sbq.size() == 0) check32("unexpected M capture pc", dbg_m_pc, 32'hFFFF_FFFF);
        else checkm($sformatf("M capture pc=%h", dbg_m_pc), m_now(), sbq.pop_front());
      end
      prev_pc = dbg_m_pc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, held_pc;
    int          cnt;
    resetn   = 1'b1;
    e_kill   = 1'b0;
    m_stall  = 1'b0;
    m_bubble = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    checkm("reset M contents", m_now(), M_RESET);
    check32("reset stall", {31'b0, e_stall_req}, 32'd0);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             6'(i * 13 + 5), vecs[i].exp, int'(vecs[i].stall));
    end

    // Kill a multiply in its tenth busy cycle.
    pc = pc_next;
    pc_next = pc_next + 32'd4;
    drive_e(ALU_MUL, 32'hFFFF_FFFD, 32'd7, 6'h3F, pc);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    e_kill = 1'b1;
    @(negedge clk);
    check32("stall while killing busy", {31'b0, e_stall_req}, 32'd1);
    @(posedge clk);
    #1;
    e_kill = 1'b0;
    drive_idle();
    @(negedge clk);
    check32("stall after kill", {31'b0, e_stall_req}, 32'd0);
    checkm("M bubble after kill", m_now(), M_RESET);
    @(posedge clk);
    #1;
    run_op("add after kill", ALU_ADD, 32'h10, 32'h20, 6'h15, 32'h30, 0);

    // Asynchronous reset in the middle of a divide, with M frozen on an earlier result.
    held_pc = pc_next;
    run_op("add before reset", ALU_ADD, 32'd1, 32'd2, 6'h2A, 32'd3, 0);
    m_stall = 1'b1;
    pc = pc_next;
    pc_next = pc_next + 32'd4;
    drive_e(ALU_DIV, 32'd100, 32'd7, 6'h01, pc);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check32("stall mid divide", {31'b0, e_stall_req}, 32'd1);
    check32("M held under m_stall", dbg_m_pc, held_pc);
    #2;
    resetn = 1'b1;
    #1;
    checkm("M async reset mid-op", m_now(), M_RESET);
    drive_idle();
    #1;
    check32("stall during reset", {31'b0, e_stall_req}, 32'd0);
    @(negedge clk);
    resetn  = 1'b0;
    m_stall = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check32("stall idle after reset", {31'b0, e_stall_req}, 32'd0);

    // m_stall held for three cycles in DONE: 33 busy-side cycles plus 3 held cycles.
    m_stall = 1'b1;
    pc = pc_next;
    pc_next = pc_next + 32'd4;
    drive_e(ALU_MUL, 32'd12345, 32'hFFFF_FFFE, 6'h33, pc);
    push_exp(6'h33, 32'hFFFF_9F8E, pc);
    cnt = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (e_stall_req) cnt++;
      @(posedge clk);
      #1;
    end
    m_stall = 1'b0;
    @(negedge clk);
    check32("stall after hold release", {31'b0, e_stall_req}, 32'd0);
    @(posedge clk);
    #1;
    drive_idle();
    check32("stall cycles with DONE hold", cnt, 32'd36);

    repeat (4) @(posedge clk);
    #1;
    check32("scoreboard drained", sbq.size(), 32'd0);
    check32("M capture count", n_captures, n_pushed);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
